fib_checker: RTL and testbench
==============================

Name: fib_checker

Overview:
- Consumer-side counterpart of the Fibonacci generator.
- Accepts a stream of bW-bit words over a valid/ready handshake and checks them against the Fibonacci sequence 1,1,2,3,5,8,... taken modulo 2^bW.
- Emits one registered verdict per accepted word and keeps saturating match and error counters.
- Sits downstream of any sequence source as a built-in self-check monitor.

Parameters:
- bW, 3, data width; all arithmetic is modulo 2^bW; bW >= 1.
- iW, 8, width of the term-index field; wraps modulo 2^iW.
- cW, 8, width of the match and error counters; both saturate at 2^cW-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_data  input  bW  word under test.
- in_ready  output  1  checker can accept a word this cycle.
- res_valid  output  1  verdict register holds a result.
- res_ready  input  1  downstream takes the result.
- res_ok  output  1  word matched the expected term, or was the acquiring 1 in HUNT.
- res_err  output  1  word mismatched while in TRACK.
- res_idx  output  iW  term index of a res_ok word (first 1 = index 1); 0 when res_ok=0.
- locked  output  1  state == TRACK.
- match_count  output  cW  saturating count of res_ok words.
- err_count  output  cW  saturating count of res_err words.

Behaviour:
- Accept condition: accept = in_valid && in_ready.
- Ready rule: in_ready = !res_valid || res_ready. This gives full throughput, so an accept and a drain may occur in the same cycle.
- Verdict timing: registered, one cycle after accept. res_* stay stable while res_valid && !res_ready.
- Result drain: res_valid is cleared on drain unless a new accept occurs in the same cycle.
- Internal state: prev, exp (bW bits each) and idx (iW bits).
- Reset: asynchronous; takes effect immediately, mid-transfer included. After reset:
  - state = HUNT, prev = 0, exp = 1, idx = 0.
  - res_valid = res_ok = res_err = 0, res_idx = 0, locked = 0.
  - Both counters = 0, in_ready = 1.
- HUNT state, on accept:
  - in_data == 1: res_ok = 1, res_idx = 1; prev <= 1, exp <= 1, idx <= 1; go to TRACK; match_count increments.
  - Any other value: verdict with res_ok = 0 and res_err = 0; no counter changes; remain in HUNT.
- TRACK state, on accept:
  - in_data == exp (match): res_ok = 1, res_idx = idx+1 (mod 2^iW); prev <= exp, exp <= exp+prev (mod 2^bW, carry dropped), idx <= idx+1; match_count increments.
  - Mismatch: res_err = 1, res_ok = 0, res_idx = 0; err_count increments; prev <= 0, exp <= 1, idx <= 0; go to HUNT.
  - The mismatching word is not reconsidered as a HUNT candidate, even if it equals 1.
- No accept: internal state and counters hold.
- Counters: never wrap; they hold at all-ones once saturated.
- bW = 1 case: the expected pattern is 1,1,0,1,1,0,...
- Index wrap: res_idx rolls from 2^iW-1 to 0 while res_ok = 1 (legal).

Test Plan:
1. bW=3, res_ready=1, feed 1,1,2,3,5,0,5,5,2,7,1,0 back-to-back -> every verdict res_ok=1; res_idx 1..12; match_count=12; err_count=0; locked=1 from the cycle after the first accept; in_ready stays 1.
2. bW=3, feed 4,6,1,1,2,4,3,1,1 -> 4 and 6: ok=0/err=0. 1,1,2: ok, idx 1..3. 4: res_err=1, err_count=1, locked=0. 3: dropped. Final 1,1: ok, idx 1,2. match_count=5.
3. Backpressure: lock with 1,1, then hold res_ready=0 and present 2 -> word accepted; res_valid=1, res_idx=3 held stable; in_ready=0. Next word 3 held with in_valid=1 is not consumed. Raise res_ready -> 3 accepted the same cycle; next verdict res_idx=4.
4. Asynchronous reset asserted mid-stream while res_valid=1 and locked=1 -> before the next clk edge: res_valid=0, locked=0, both counters 0, in_ready=1. After release, feed 1 -> res_idx=1.
5. cW=2, bW=3: repeat the pair 1,7 five times -> each 1 acquires lock, each 7 errors; err_count saturates at 3 and match_count saturates at 3.
6. bW=1, iW=2: feed 1,1,0,1,1 -> all ok; res_idx 1,2,3,0,1 (index wrap).

Source files
------------

// File: rtl/fib_checker_if.sv
// Valid/ready word stream into the Fibonacci checker and its registered verdict stream out.
interface fib_checker_if #(
  parameter int unsigned bW = 3,
  parameter int unsigned iW = 8
);
  logic          in_valid;
  logic [bW-1:0] in_data;
  logic          in_ready;
  logic          res_valid;
  logic          res_ready;
  logic          res_ok;
  logic          res_err;
  logic [iW-1:0] res_idx;

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_ok, res_err, res_idx
  );

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_ok, res_err, res_idx
  );
endinterface

// File: rtl/fib_checker.sv
// Checks an incoming word stream against Fibonacci mod 2^bW, acquiring lock on a 1 and
// producing one registered verdict per accepted word plus saturating match/error counters.
module fib_checker #(
  parameter int unsigned bW = 3,
  parameter int unsigned iW = 8,
  parameter int unsigned cW = 8
) (
  input  logic          clk,
  input  logic          rst,
  fib_checker_if.slave  bus,
  output logic          locked,
  output logic [cW-1:0] match_count,
  output logic [cW-1:0] err_count
);

  typedef enum logic {HUNT, TRACK} state_t;

  state_t        state;
  logic [bW-1:0] prev;
  logic [bW-1:0] exp;
  logic [iW-1:0] idx;
  logic          accept;

  // Full-throughput handshake: a held verdict being drained frees the slot in the same cycle.
  assign bus.in_ready = !bus.res_valid || bus.res_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign locked       = (state == TRACK);

  function automatic logic [cW-1:0] sat_inc(input logic [cW-1:0] v);
    return (v == {cW{1'b1}}) ? v : v + cW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= HUNT;
      prev          <= '0;
      exp           <= bW'(1);
      idx           <= '0;
      bus.res_valid <= 1'b0;
      bus.res_ok    <= 1'b0;
      bus.res_err   <= 1'b0;
      bus.res_idx   <= '0;
      match_count   <= '0;
      err_count     <= '0;
    end else if (accept) begin
      bus.res_valid <= 1'b1;
      unique case (state)
        HUNT: begin
          bus.res_err <= 1'b0;
          if (bus.in_data == bW'(1)) begin
            bus.res_ok  <= 1'b1;
            bus.res_idx <= iW'(1);
            prev        <= bW'(1);
            exp         <= bW'(1);
            idx         <= iW'(1);
            state       <= TRACK;
            match_count <= sat_inc(match_count);
          end else begin
            bus.res_ok  <= 1'b0;
            bus.res_idx <= '0;
          end
        end
        TRACK: begin
          if (bus.in_data == exp) begin
            bus.res_ok  <= 1'b1;
            bus.res_err <= 1'b0;
            bus.res_idx <= idx + iW'(1);
            prev        <= exp;
            exp         <= exp + prev;
            idx         <= idx + iW'(1);
            match_count <= sat_inc(match_count);
          end else begin
            // A mismatching word drops lock and is never reused as an acquisition candidate.
            bus.res_ok  <= 1'b0;
            bus.res_err <= 1'b1;
            bus.res_idx <= '0;
            prev        <= '0;
            exp         <= bW'(1);
            idx         <= '0;
            state       <= HUNT;
            err_count   <= sat_inc(err_count);
          end
        end
        default: state <= HUNT;
      endcase
    end else if (bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fib_checker.sv
// Randomized and directed bench for fib_checker against a term-number Fibonacci reference model.
module tb_fib_checker;

  logic clk;
  logic rst;

  fib_checker_if #(.bW(3), .iW(8)) bus_a ();
  fib_checker_if #(.bW(3), .iW(8)) bus_b ();
  fib_checker_if #(.bW(1), .iW(2)) bus_c ();

  logic       locked_a, locked_b, locked_c;
  logic [7:0] mc_a, ec_a, mc_c, ec_c;
  logic [1:0] mc_b, ec_b;

  fib_checker #(.bW(3), .iW(8), .cW(8)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .locked(locked_a), .match_count(mc_a), .err_count(ec_a));
  fib_checker #(.bW(3), .iW(8), .cW(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .locked(locked_b), .match_count(mc_b), .err_count(ec_b));
  fib_checker #(.bW(1), .iW(2), .cW(8)) dut_c (
    .clk(clk), .rst(rst), .bus(bus_c), .locked(locked_c), .match_count(mc_c), .err_count(ec_c));

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Reference model: tracks term number n of the locked sequence, not prev/exp registers.
  int m_bw, m_iw, m_cw;
  bit m_rv, m_ok, m_err, m_locked, m_ready;
  int m_idx, m_n, m_mc, m_ec;

  // Observed DUT values from the last step.
  bit o_ready, o_rv, o_ok, o_err, o_locked;
  int o_idx, o_mc, o_ec;

  function automatic int fib_mod(input int k, input int bw);
    int a = 1, b = 1, t;
    for (int i = 3; i <= k; i++) begin
      t = (a + b) % (1 << bw);
      a = b;
      b = t;
    end
    return b % (1 << bw);
  endfunction

  task automatic model_reset(input int bw, input int iw, input int cw);
    m_bw = bw; m_iw = iw; m_cw = cw;
    m_rv = 0; m_ok = 0; m_err = 0; m_locked = 0;
    m_idx = 0; m_n = 0; m_mc = 0; m_ec = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit rr);
    m_ready = !m_rv || rr;
    if (v && m_ready) begin
      m_rv = 1;
      if (!m_locked) begin
        m_err = 0;
        if (d == 1) begin
          m_ok = 1; m_idx = 1; m_n = 1; m_locked = 1;
          if (m_mc < (1 << m_cw) - 1) m_mc++;
        end else begin
          m_ok = 0; m_idx = 0;
        end
      end else if (d == fib_mod(m_n + 1, m_bw)) begin
        m_n++;
        m_ok = 1; m_err = 0; m_idx = m_n % (1 << m_iw);
        if (m_mc < (1 << m_cw) - 1) m_mc++;
      end else begin
        m_ok = 0; m_err = 1; m_idx = 0; m_locked = 0; m_n = 0;
        if (m_ec < (1 << m_cw) - 1) m_ec++;
      end
    end else if (rr) begin
      m_rv = 0;
    end
  endtask

  // One clock of stimulus on the selected instance; samples ready before and results after the edge.
  task automatic step(input int sel, input bit v, input int d, input bit rr);
    case (sel)
      0: begin bus_a.in_valid = v; bus_a.in_data = 3'(d); bus_a.res_ready = rr; end
      1: begin bus_b.in_valid = v; bus_b.in_data = 3'(d); bus_b.res_ready = rr; end
      default: begin bus_c.in_valid = v; bus_c.in_data = 1'(d); bus_c.res_ready = rr; end
    endcase
    #1;
    o_ready = (sel == 0) ? bus_a.in_ready : (sel == 1) ? bus_b.in_ready : bus_c.in_ready;
    @(posedge clk);
    model_step(v, d, rr);
    #1;
    case (sel)
      0: begin
        o_rv = bus_a.res_valid; o_ok = bus_a.res_ok; o_err = bus_a.res_err;
        o_idx = int'(bus_a.res_idx); o_locked = locked_a; o_mc = int'(mc_a); o_ec = int'(ec_a);
      end
      1: begin
        o_rv = bus_b.res_valid; o_ok = bus_b.res_ok; o_err = bus_b.res_err;
        o_idx = int'(bus_b.res_idx); o_locked = locked_b; o_mc = int'(mc_b); o_ec = int'(ec_b);
      end
      default: begin
        o_rv = bus_c.res_valid; o_ok = bus_c.res_ok; o_err = bus_c.res_err;
        o_idx = int'(bus_c.res_idx); o_locked = locked_c; o_mc = int'(mc_c); o_ec = int'(ec_c);
      end
    endcase
  endtask

  task automatic idle_all();
    bus_a.in_valid = 0; bus_a.in_data = '0; bus_a.res_ready = 1;
    bus_b.in_valid = 0; bus_b.in_data = '0; bus_b.res_ready = 1;
    bus_c.in_valid = 0; bus_c.in_data = '0; bus_c.res_ready = 1;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1;
    #3;
    checks++;
    if ({bus_a.res_valid, bus_a.res_ok, bus_a.res_err, locked_a, bus_a.in_ready} !== 5'b00001 ||
        bus_a.res_idx !== 8'd0 || mc_a !== 8'd0 || ec_a !== 8'd0) begin
      errors++;
      $display("FAIL reset_a: got v=%0b ok=%0b err=%0b lk=%0b rdy=%0b idx=%0d mc=%0d ec=%0d want 0,0,0,0,1,0,0,0",
               bus_a.res_valid, bus_a.res_ok, bus_a.res_err, locked_a, bus_a.in_ready,
               bus_a.res_idx, mc_a, ec_a);
    end
    checks++;
    if ({bus_b.res_valid, locked_b, bus_b.in_ready, bus_c.res_valid, locked_c, bus_c.in_ready} !== 6'b001001 ||
        mc_b !== 2'd0 || ec_b !== 2'd0 || mc_c !== 8'd0 || ec_c !== 8'd0) begin
      errors++;
      $display("FAIL reset_bc: got vb=%0b lkb=%0b rdyb=%0b vc=%0b lkc=%0b rdyc=%0b want 0,0,1,0,0,1",
               bus_b.res_valid, locked_b, bus_b.in_ready, bus_c.res_valid, locked_c, bus_c.in_ready);
    end
    @(negedge clk);
    rst = 0;
    #1;
  endtask

  task automatic test_lock_sequence();
    int seq[12] = '{1, 1, 2, 3, 5, 0, 5, 5, 2, 7, 1, 0};
    do_reset();
    model_reset(3, 8, 8);
    for (int i = 0; i < 12; i++) begin
      step(0, 1, seq[i], 1);
      checks++;
      if (o_ready !== 1'b1 || o_rv !== 1'b1 || o_ok !== 1'b1 || o_err !== 1'b0 ||
          o_idx !== i + 1 || o_locked !== 1'b1) begin
        errors++;
        $display("FAIL lock_seq[%0d]: got rdy=%0b v=%0b ok=%0b err=%0b idx=%0d lk=%0b want 1,1,1,0,%0d,1",
                 i, o_ready, o_rv, o_ok, o_err, o_idx, o_locked, i + 1);
      end
    end
    step(0, 0, 0, 1);
    checks++;
    if (o_mc !== 12 || o_ec !== 0 || o_rv !== 1'b0 || o_mc !== m_mc) begin
      errors++;
      $display("FAIL lock_seq_counts: got mc=%0d ec=%0d v=%0b want 12,0,0", o_mc, o_ec, o_rv);
    end
  endtask

  task automatic test_mismatch();
    int seq[9] = '{4, 6, 1, 1, 2, 4, 3, 1, 1};
    do_reset();
    model_reset(3, 8, 8);
    for (int i = 0; i < 9; i++) begin
      step(0, 1, seq[i], 1);
      checks++;
      if (o_rv !== m_rv || o_ok !== m_ok || o_err !== m_err || o_idx !== m_idx ||
          o_locked !== m_locked || o_mc !== m_mc || o_ec !== m_ec) begin
        errors++;
        $display("FAIL mismatch[%0d]: got v=%0b ok=%0b err=%0b idx=%0d lk=%0b mc=%0d ec=%0d want %0b,%0b,%0b,%0d,%0b,%0d,%0d",
                 i, o_rv, o_ok, o_err, o_idx, o_locked, o_mc, o_ec,
                 m_rv, m_ok, m_err, m_idx, m_locked, m_mc, m_ec);
      end
    end
    checks++;
    if (o_mc !== 5 || o_ec !== 1 || o_idx !== 2) begin
      errors++;
      $display("FAIL mismatch_final: got mc=%0d ec=%0d idx=%0d want 5,1,2", o_mc, o_ec, o_idx);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    model_reset(3, 8, 8);
    step(0, 1, 1, 1);
    step(0, 1, 1, 1);
    step(0, 0, 0, 1);
    step(0, 1, 2, 0);
    checks++;
    if (o_ready !== 1'b1 || o_rv !== 1'b1 || o_ok !== 1'b1 || o_idx !== 3 || bus_a.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: got rdy_before=%0b v=%0b ok=%0b idx=%0d rdy_after=%0b want 1,1,1,3,0",
               o_ready, o_rv, o_ok, o_idx, bus_a.in_ready);
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 3, 0);
      checks++;
      if (o_ready !== 1'b0 || o_rv !== 1'b1 || o_idx !== 3 || o_mc !== 3 || o_idx !== m_idx) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got rdy=%0b v=%0b idx=%0d mc=%0d want 0,1,3,3", i, o_ready, o_rv, o_idx, o_mc);
      end
    end
    step(0, 1, 3, 1);
    checks++;
    if (o_ready !== 1'b1 || o_rv !== 1'b1 || o_ok !== 1'b1 || o_idx !== 4 || o_mc !== m_mc) begin
      errors++;
      $display("FAIL bp_release: got rdy=%0b v=%0b ok=%0b idx=%0d mc=%0d want 1,1,1,4,%0d",
               o_ready, o_rv, o_ok, o_idx, o_mc, m_mc);
    end
    step(0, 0, 0, 1);
  endtask

  task automatic test_async_reset();
    do_reset();
    model_reset(3, 8, 8);
    step(0, 1, 1, 1);
    step(0, 1, 1, 1);
    step(0, 1, 2, 1);
    #2;
    rst = 1;
    #1;
    checks++;
    if (bus_a.res_valid !== 1'b0 || locked_a !== 1'b0 || mc_a !== 8'd0 || ec_a !== 8'd0 || bus_a.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got v=%0b lk=%0b mc=%0d ec=%0d rdy=%0b want 0,0,0,0,1",
               bus_a.res_valid, locked_a, mc_a, ec_a, bus_a.in_ready);
    end
    @(negedge clk);
    rst = 0;
    #1;
    model_reset(3, 8, 8);
    step(0, 1, 1, 1);
    checks++;
    if (o_rv !== 1'b1 || o_ok !== 1'b1 || o_idx !== 1 || o_locked !== 1'b1) begin
      errors++;
      $display("FAIL async_reacquire: got v=%0b ok=%0b idx=%0d lk=%0b want 1,1,1,1", o_rv, o_ok, o_idx, o_locked);
    end
    step(0, 0, 0, 1);
  endtask

  task automatic test_saturation();
    do_reset();
    model_reset(3, 8, 2);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, (i % 2 == 0) ? 1 : 7, 1);
      checks++;
      if (o_ok !== m_ok || o_err !== m_err || o_mc !== m_mc || o_ec !== m_ec || o_locked !== m_locked) begin
        errors++;
        $display("FAIL sat[%0d]: got ok=%0b err=%0b mc=%0d ec=%0d lk=%0b want %0b,%0b,%0d,%0d,%0b",
                 i, o_ok, o_err, o_mc, o_ec, o_locked, m_ok, m_err, m_mc, m_ec, m_locked);
      end
    end
    checks++;
    if (o_mc !== 3 || o_ec !== 3) begin
      errors++;
      $display("FAIL sat_final: got mc=%0d ec=%0d want 3,3", o_mc, o_ec);
    end
    step(1, 0, 0, 1);
  endtask

  task automatic test_narrow_wrap();
    int seq[5]  = '{1, 1, 0, 1, 1};
    int want[5] = '{1, 2, 3, 0, 1};
    do_reset();
    model_reset(1, 2, 8);
    for (int i = 0; i < 5; i++) begin
      step(2, 1, seq[i], 1);
      checks++;
      if (o_rv !== 1'b1 || o_ok !== 1'b1 || o_err !== 1'b0 || o_idx !== want[i] || o_idx !== m_idx) begin
        errors++;
        $display("FAIL narrow[%0d]: got v=%0b ok=%0b err=%0b idx=%0d want 1,1,0,%0d", i, o_rv, o_ok, o_err, o_idx, want[i]);
      end
    end
    checks++;
    if (o_mc !== 5 || o_ec !== 0) begin
      errors++;
      $display("FAIL narrow_counts: got mc=%0d ec=%0d want 5,0", o_mc, o_ec);
    end
    step(2, 0, 0, 1);
  endtask

  task automatic test_random();
    bit v, rr;
    int d;
    do_reset();
    model_reset(3, 8, 8);
    for (int i = 0; i < 1500; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) != 0) d = m_locked ? fib_mod(m_n + 1, 3) : 1;
      else d = int'($urandom_range(0, 7));
      step(0, v, d, rr);
      checks++;
      if (o_ready !== m_ready) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %0b want %0b", i, o_ready, m_ready);
      end
      checks++;
      if (o_rv !== m_rv || (m_rv && (o_ok !== m_ok || o_err !== m_err || o_idx !== m_idx))) begin
        errors++;
        $display("FAIL rand_verdict[%0d]: got v=%0b ok=%0b err=%0b idx=%0d want %0b,%0b,%0b,%0d",
                 i, o_rv, o_ok, o_err, o_idx, m_rv, m_ok, m_err, m_idx);
      end
      checks++;
      if (o_locked !== m_locked || o_mc !== m_mc || o_ec !== m_ec) begin
        errors++;
        $display("FAIL rand_state[%0d]: got lk=%0b mc=%0d ec=%0d want %0b,%0d,%0d",
                 i, o_locked, o_mc, o_ec, m_locked, m_mc, m_ec);
      end
    end
  endtask

  initial begin
    rst = 1;
    idle_all();
    test_reset();
    test_lock_sequence();
    test_mismatch();
    test_backpressure();
    test_async_reset();
    test_saturation();
    test_narrow_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
